// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl
// ---------------
// Sequencer for a dual-port sample RAM used as a programmable delay/echo
// line. One input sample per cycle is written at wr_ptr. The same cycle
// reads the sample written delay_q samples earlier, at wr_ptr + ram_offset.
// The read data comes back after RD_LAT cycles and is re-emitted as the
// delayed stream. Until the buffer holds delay_q real samples since the
// last (re)start, the output is forced to zero so stale RAM contents never
// leak out.
//
// Handshake: the input side is valid-only (no ready, no backpressure).
// A sample is taken on every cycle where acc = en && in_valid && state != IDLE.
// Every taken sample produces exactly one out_valid pulse RD_LAT cycles later.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   en                 controller enable; 0 forces IDLE (wr_ptr is kept)
//   in_valid/in_sample input sample stream
//   cfg_load/delay_cfg one-cycle pulse latching the delay (0 is treated as 1)
//   ram_wr/ram_rd      RAM write/read strobes (both equal acc)
//   ram_wr_addr        RAM write address, also the read base
//   ram_offset         read offset = -delay_q mod depth
//   ram_din            RAM write data (holds the last accepted sample)
//   ram_dout_read      RAM read data, captured on the RD_LAT-th edge after the strobe
//   out_valid/out_sample delayed sample stream
//   filled             buffer holds at least delay_q valid samples (state RUN)
//
// RD_LAT must be at least 2.
module delay_line_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int RD_LAT        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_sample,
  input  logic                     cfg_load,
  input  logic [ADDRESS_WIDTH-1:0] delay_cfg,
  output logic                     ram_wr,
  output logic                     ram_rd,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [ADDRESS_WIDTH-1:0] ram_offset,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout_read,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_sample,
  output logic                     filled
);

  localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                   state, state_n;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] delay_q;
  logic [ADDRESS_WIDTH-1:0] fill_cnt, fill_n;
  logic [ADDRESS_WIDTH-1:0] cfg_clamped;
  logic [ADDRESS_WIDTH-1:0] base_cnt, base_dly;
  logic [DATA_WIDTH-1:0]    din_q;
  logic [DATA_WIDTH-1:0]    dout_q;
  logic                     acc;
  logic                     zero_flag;
  logic [RD_LAT-1:0]        vld_sr;
  logic [RD_LAT-1:0]        zf_sr;

  // A zero delay would read the location being written; treat it as 1.
  assign cfg_clamped = (delay_cfg == '0) ? ONE : delay_cfg;

  assign acc = en && in_valid && (state != IDLE);

  // RAM side
  assign ram_wr      = acc;
  assign ram_rd      = acc;
  assign ram_wr_addr = wr_ptr;
  assign ram_din     = acc ? in_sample : din_q;
  // Two's-complement negation gives (depth - delay_q) mod depth directly.
  assign ram_offset  = '0 - delay_q;

  assign filled = (state == RUN);

  // Next state / fill counter. A cfg_load in an active state restarts the
  // fill from zero under the new delay in the same cycle, so a sample
  // accepted alongside it counts as the first sample of the new fill.
  always_comb begin
    state_n   = state;
    fill_n    = fill_cnt;
    base_cnt  = fill_cnt;
    base_dly  = delay_q;
    if (cfg_load) begin
      base_cnt = '0;
      base_dly = cfg_clamped;
    end
    zero_flag = (base_cnt < base_dly);

    if (!en) begin
      state_n = IDLE;
    end else if (state == IDLE) begin
      state_n = FILL;
      fill_n  = '0;
    end else begin
      fill_n = base_cnt;
      if (acc && (base_cnt < base_dly)) begin
        fill_n = base_cnt + ONE;
      end
      state_n = (fill_n >= base_dly) ? RUN : FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      delay_q  <= ONE;
      fill_cnt <= '0;
      din_q    <= '0;
    end else begin
      state    <= state_n;
      fill_cnt <= fill_n;
      if (cfg_load) begin
        delay_q <= cfg_clamped;
      end
      if (acc) begin
        wr_ptr <= wr_ptr + ONE;
        din_q  <= in_sample;
      end
    end
  end

  // Valid / zero-flag pipeline. Stage RD_LAT-1 is the output stage; the RAM
  // data is captured on the edge that moves a sample into that stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      zf_sr  <= '0;
      dout_q <= '0;
    end else begin
      vld_sr <= {vld_sr[RD_LAT-2:0], acc};
      zf_sr  <= {zf_sr[RD_LAT-2:0], zero_flag};
      if (vld_sr[RD_LAT-2]) begin
        dout_q <= ram_dout_read;
      end
    end
  end

  assign out_valid  = vld_sr[RD_LAT-1];
  assign out_sample = (out_valid && !zf_sr[RD_LAT-1]) ? dout_q : '0;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Testbench for delay_line_ctrl (ADDRESS_WIDTH=3 so every run wraps the
// 8-entry buffer). A behavioural RAM sits on the RAM ports. Expected values
// come from a reference model that works on the list of accepted samples:
// the k-th sample since the last restart yields the sample accepted
// delay samples earlier, or 0 while k < delay.
module tb_delay_line_ctrl;
  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en, in_valid, cfg_load;
  logic [DW-1:0] in_sample;
  logic [AW-1:0] delay_cfg;
  logic          ram_wr, ram_rd, out_valid, filled;
  logic [AW-1:0] ram_wr_addr, ram_offset;
  logic [DW-1:0] ram_din, ram_dout_read, out_sample;

  delay_line_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_sample(in_sample),
    .cfg_load(cfg_load), .delay_cfg(delay_cfg), .ram_wr(ram_wr), .ram_rd(ram_rd),
    .ram_wr_addr(ram_wr_addr), .ram_offset(ram_offset), .ram_din(ram_din),
    .ram_dout_read(ram_dout_read), .out_valid(out_valid), .out_sample(out_sample),
    .filled(filled)
  );

  // ---------------- behavioural RAM ----------------
  // One registered read stage: data is visible the cycle after the strobe
  // and the controller captures it on the following edge (RD_LAT = 2).
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] rd_addr;
  assign rd_addr       = ram_wr_addr + ram_offset;
  assign ram_dout_read = rd_q;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rd_q = '0;
  end
  always @(posedge clk) begin
    if (ram_wr) mem[ram_wr_addr] <= ram_din;
    if (ram_rd) rd_q <= mem[rd_addr];
  end

  // ---------------- scoreboard / model ----------------
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  logic [DW-1:0] hist[$];
  bit            m_active;
  int            m_d;
  int            m_cnt;
  logic [AW-1:0] m_wp;
  logic [DW-1:0] m_din;
  bit            m_filled;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); due_q.delete(); hist.delete();
    m_active = 0; m_d = 1; m_cnt = 0; m_wp = '0; m_din = '0; m_filled = 0;
  endtask

  task automatic model_update();
    bit            acc;
    int            nd;
    logic [DW-1:0] e_s;
    acc = en && in_valid && m_active;
    nd  = (delay_cfg == 0) ? 1 : int'(delay_cfg);
    if (!en) begin
      if (cfg_load) m_d = nd;
      m_active = 0;
    end else if (!m_active) begin
      if (cfg_load) m_d = nd;
      m_active = 1;
      m_cnt = 0;
    end else begin
      if (cfg_load) begin
        m_d = nd;
        m_cnt = 0;
      end
      if (acc) begin
        if (m_cnt < m_d) e_s = '0;
        else e_s = hist[hist.size() - m_d];
        exp_q.push_back(e_s);
        due_q.push_back(cyc + RD_LAT);
        if (m_cnt < m_d) m_cnt++;
      end
    end
    if (acc) begin
      hist.push_back(in_sample);
      m_wp  = m_wp + 1'b1;
      m_din = in_sample;
    end
    m_filled = m_active && (m_cnt >= m_d);
    cyc++;
  endtask

  task automatic check_cycle();
    bit acc_e;
    acc_e = en && in_valid && m_active;
    chk("ram_wr", ram_wr, acc_e);
    chk("ram_rd", ram_rd, acc_e);
    chk("ram_wr_addr", ram_wr_addr, m_wp);
    chk("ram_offset", ram_offset, (DEPTH - m_d) % DEPTH);
    chk("ram_din", ram_din, acc_e ? in_sample : m_din);
    chk("filled", filled, m_filled);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      chk("out_valid", out_valid, 1);
      chk("out_sample", out_sample, exp_q[0]);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      chk("out_valid_idle", out_valid, 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit e, input bit v, input logic [DW-1:0] s,
                       input bit c, input logic [AW-1:0] dc);
    en = e; in_valid = v; in_sample = s; cfg_load = c; delay_cfg = dc;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input bit e, input bit v, input logic [DW-1:0] s,
                      input bit c, input logic [AW-1:0] dc);
    drive(e, v, s, c, dc);
    advance();
  endtask

  typedef struct {
    bit            e;
    bit            v;
    logic [DW-1:0] s;
    bit            c;
    logic [AW-1:0] dc;
    bit            xv;
    logic [DW-1:0] xs;
    bit            xf;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic delay 4, samples 1..10: outputs 0,0,0,0,1..6, filled after 4th accept.
    tbl[0]  = '{1'b0, 1'b0, 8'd0,  1'b1, 3'd4, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'd0,  1'b0, 3'd0, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'd1,  1'b0, 3'd0, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'd2,  1'b0, 3'd0, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'd3,  1'b0, 3'd0, 1'b1, 8'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'd4,  1'b0, 3'd0, 1'b1, 8'd0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'd5,  1'b0, 3'd0, 1'b1, 8'd0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 8'd6,  1'b0, 3'd0, 1'b1, 8'd0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'd7,  1'b0, 3'd0, 1'b1, 8'd1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 8'd8,  1'b0, 3'd0, 1'b1, 8'd2, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'd9,  1'b0, 3'd0, 1'b1, 8'd3, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 8'd10, 1'b0, 3'd0, 1'b1, 8'd4, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'd0,  1'b0, 3'd0, 1'b1, 8'd5, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 8'd0,  1'b0, 3'd0, 1'b1, 8'd6, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 8'd0,  1'b0, 3'd0, 1'b0, 8'd0, 1'b1};

    en = 0; in_valid = 0; in_sample = '0; cfg_load = 0; delay_cfg = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_filled", filled, 0);
    chk("rst_wr_addr", ram_wr_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_offset_delay1", ram_offset, DEPTH - 1);
    rst_n = 1;
    advance();
    repeat (2) step(0, 1, 8'($urandom), 0, '0);

    // Table-driven basic delay
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].e, tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].dc);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].xv);
      if (tbl[i].xv) chk($sformatf("tbl%0d_sample", i), out_sample, tbl[i].xs);
      chk($sformatf("tbl%0d_filled", i), filled, tbl[i].xf);
      advance();
    end

    // Reset mid-stream: in-flight samples must be flushed
    for (int i = 0; i < 3; i++) step(1, 1, 8'(100 + i), 0, '0);
    #2 rst_n = 0;
    #1;
    chk("midrst_ram_wr", ram_wr, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_filled", filled, 0);
    chk("midrst_wr_addr", ram_wr_addr, 0);
    chk("midrst_din", ram_din, 0);
    chk("midrst_out_sample", out_sample, 0);
    en = 0; in_valid = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    advance();
    for (int i = 0; i < 6; i++) step(0, 1, 8'($urandom), 0, '0);

    // Wrap-around: delay 5, samples 1..20
    step(0, 0, '0, 1, 3'd5);
    chk("wrap_offset", ram_offset, 3);
    step(1, 0, '0, 0, '0);
    for (int i = 1; i <= 20; i++) step(1, 1, 8'(i), 0, '0);
    repeat (3) step(1, 0, '0, 0, '0);

    // Reconfigure in RUN at delay 4 -> delay 2 alongside a sample
    step(0, 0, '0, 1, 3'd4);
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < 8; i++) step(1, 1, 8'(30 + i), 0, '0);
    chk("reconf_filled_before", filled, 1);
    step(1, 1, 8'd50, 1, 3'd2);
    chk("reconf_filled_drop", filled, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 8'(51 + i), 0, '0);
    repeat (3) step(1, 0, '0, 0, '0);

    // Gaps, then enable dropped mid-stream, then re-enable
    for (int i = 0; i < 12; i++) step(1, i[0], 8'(60 + i), 0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(80 + i), 0, '0);
    step(1, 1, 8'd90, 0, '0);
    for (int i = 0; i < 8; i++) step(1, 1, 8'(91 + i), 0, '0);
    repeat (3) step(1, 0, '0, 0, '0);

    // Clamp: delay_cfg 0 acts as delay 1
    step(0, 0, '0, 1, 3'd0);
    chk("clamp_offset", ram_offset, DEPTH - 1);
    step(1, 0, '0, 0, '0);
    for (int i = 0; i < 6; i++) step(1, 1, 8'(110 + i), 0, '0);
    repeat (3) step(1, 0, '0, 0, '0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)));
    end
    repeat (4) step(0, 0, '0, 0, '0);
    chk("drain_empty", due_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
